pix_loader: RTL and testbench

Downstream consumer of the UART command path for downloaded-image mode. While pixel-enable is high, it takes debounced UART bytes with their `data_valid` strobe and parses a 4-byte resolution header. It then writes the following pixel bytes sequentially into the single-port frame-buffer BRAM that the display side reads. It reports busy, done and error status back to the command handler that gates pixel-enable.

---
 rtl/pix_loader_pkg.sv | 16 +
 rtl/pix_loader_idle_timeout.sv | 25 ++
 rtl/pix_loader.sv | 110 +++++++++++
 tb/tb_pix_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pix_loader_pkg.sv
// pix_loader_pkg: loader FSM encoding and frame geometry shared with the display read side.
package pix_loader_pkg;

    typedef enum logic [2:0] {IDLE, HDR, CHECK, DATA, DONE, ERR} state_t;

    localparam int HDR_BYTES      = 4;
    localparam int FRAME_W        = 640;
    localparam int FRAME_H        = 480;
    localparam int MAX_PIXELS_DEF = FRAME_W * FRAME_H;

    // A dimension must fit in 10 bits and be nonzero.
    function automatic logic dims_bad(input logic [15:0] w, input logic [15:0] h);
        return (w[15:10] != '0) || (h[15:10] != '0) || (w == '0) || (h == '0);
    endfunction

endpackage

// File: rtl/pix_loader_idle_timeout.sv
// idle_timeout: reloadable down-counter that flags CYC running cycles without a clear.
module idle_timeout #(
    parameter int CYC = 10_000_000
) (
    input  logic CLK,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (reset || !run || clear)
            cnt <= W'(CYC - 1);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = run && !clear && (cnt == '0);

endmodule

// File: rtl/pix_loader.sv
// pix_loader: parses a 4-byte W/H header from UART bytes and streams the pixels into the frame-buffer BRAM.
module pix_loader
    import pix_loader_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int MAX_PIXELS  = MAX_PIXELS_DEF,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              data_valid,
    input  logic [7:0]        rx_byte,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic [9:0]        img_w,
    output logic [9:0]        img_h,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    state_t            state, state_n;
    logic              pix_en_q;
    logic [1:0]        hdr_cnt;
    logic [31:0]       hdr;
    logic [19:0]       prod, total;
    logic [ADDR_W-1:0] pix_cnt;
    logic              rise, expired, hdr_last, pix_last, wr, bad;

    assign rise     = pix_en && !pix_en_q;
    assign prod     = {10'd0, hdr[25:16]} * {10'd0, hdr[9:0]};
    assign bad      = dims_bad(hdr[31:16], hdr[15:0]) || (32'(prod) > 32'(MAX_PIXELS));
    assign hdr_last = hdr_cnt == 2'(HDR_BYTES - 1);
    assign pix_last = 32'(pix_cnt) + 32'd1 == 32'(total);
    // An abort in the same cycle as a strobe must drop the byte.
    assign wr       = (state == DATA) && data_valid && pix_en;
    assign load_busy = (state == HDR) || (state == CHECK) || (state == DATA);

    idle_timeout #(.CYC(TIMEOUT_CYC)) u_timeout (
        .CLK     (CLK),
        .reset   (reset),
        .run     ((state == HDR) || (state == DATA)),
        .clear   (data_valid),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rise) state_n = HDR;
            HDR:     if (!pix_en || expired) state_n = ERR;
                     else if (data_valid && hdr_last) state_n = CHECK;
            CHECK:   state_n = (!pix_en || data_valid || bad) ? ERR : DATA;
            DATA:    if (!pix_en || expired) state_n = ERR;
                     else if (data_valid && pix_last) state_n = DONE;
            DONE:    state_n = IDLE;
            ERR:     if (!pix_en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            pix_en_q  <= 1'b0;
            hdr_cnt   <= '0;
            hdr       <= '0;
            total     <= '0;
            pix_cnt   <= '0;
            img_w     <= '0;
            img_h     <= '0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_n;
            pix_en_q  <= pix_en;
            load_done <= state == DONE;
            bram_en   <= wr;
            bram_we   <= wr;
            bram_addr <= wr ? pix_cnt : '0;
            bram_din  <= wr ? rx_byte : '0;
            if (state == IDLE && rise) begin
                hdr_cnt  <= '0;
                pix_cnt  <= '0;
                load_err <= 1'b0;
            end else if (state_n == ERR) begin
                load_err <= 1'b1;
            end
            if (state == HDR && data_valid && pix_en) begin
                hdr     <= {hdr[23:0], rx_byte};
                hdr_cnt <= hdr_cnt + 1'b1;
            end
            if (state == CHECK && state_n == DATA) begin
                img_w <= hdr[25:16];
                img_h <= hdr[9:0];
                total <= prod;
            end
            if (wr)
                pix_cnt <= pix_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pix_loader.sv
// tb_pix_loader: table-driven header/image loads plus hand-written abort, timeout, back-to-back and reset sequences.
module tb_pix_loader;

    logic        CLK = 1'b0;
    logic        reset, pix_en, data_valid;
    logic [7:0]  rx_byte;
    logic        bram_en, bram_we;
    logic [18:0] bram_addr;
    logic [7:0]  bram_din;
    logic [9:0]  img_w, img_h;
    logic        load_busy, load_done, load_err;

    int          checks = 0, errors = 0, done_cnt = 0, d0 = 0, n = 0;
    logic [26:0] exp_q[$];
    logic [26:0] e;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        bit          ok;
    } vec_t;
    vec_t vecs[6];

    always #5 CLK = ~CLK;

    pix_loader #(.TIMEOUT_CYC(100)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .pix_en     (pix_en),
        .data_valid (data_valid),
        .rx_byte    (rx_byte),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .img_w      (img_w),
        .img_h      (img_h),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data_valid = 1'b1;
        rx_byte    = b;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic pixel(input int a, input logic [7:0] b);
        exp_q.push_back({19'(a), b});
        send(b);
    endtask

    task automatic header(input logic [15:0] w, input logic [15:0] h);
        send(w[15:8]);
        send(w[7:0]);
        send(h[15:8]);
        send(h[7:0]);
    endtask

    task automatic start();
        pix_en = 1'b1;
        tick();
        chk("busy_on_start", 32'(load_busy), 32'd1);
        chk("err_cleared", 32'(load_err), 32'd0);
    endtask

    // Scoreboard: every observed write must match the oldest expected pixel.
    always @(negedge CLK) begin
        if (load_done) done_cnt++;
        if (bram_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected", bram_addr, bram_din);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bram_addr), 32'(e[26:8]));
                chk("wr_data", 32'(bram_din), 32'(e[7:0]));
                chk("wr_en", 32'(bram_en), 32'd1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'd4,    16'd2,   1'b1};
        vecs[1] = '{16'd640,  16'd481, 1'b0};
        vecs[2] = '{16'd3,    16'd3,   1'b1};
        vecs[3] = '{16'd0,    16'd5,   1'b0};
        vecs[4] = '{16'd1024, 16'd1,   1'b0};
        vecs[5] = '{16'd1023, 16'd1,   1'b1};

        reset = 1'b1; pix_en = 1'b0; data_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) tick();
        chk("rst_we", 32'(bram_we), 32'd0);
        chk("rst_en", 32'(bram_en), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_img", {12'd0, img_w, img_h}, 32'd0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            start();
            header(vecs[k].w, vecs[k].h);
            tick();
            if (vecs[k].ok) begin
                d0 = done_cnt;
                chk("img_w", 32'(img_w), 32'(vecs[k].w));
                chk("img_h", 32'(img_h), 32'(vecs[k].h));
                n = int'(vecs[k].w) * int'(vecs[k].h);
                for (int i = 0; i < n; i++) pixel(i, 8'(i + 1));
                tick();
                tick();
                chk("done_once", 32'(done_cnt - d0), 32'd1);
                chk("ok_busy", 32'(load_busy), 32'd0);
                chk("ok_err", 32'(load_err), 32'd0);
                send(8'hAA);
                send(8'h55);
            end else begin
                chk("hdr_err", 32'(load_err), 32'd1);
                chk("hdr_err_busy", 32'(load_busy), 32'd0);
                send(8'h11);
            end
            pix_en = 1'b0;
            tick();
            tick();
            chk("err_sticky", 32'(load_err), 32'(!vecs[k].ok));
        end

        // Abort at pixel 3 of 8, with the abort coinciding with a strobe.
        start();
        header(16'd4, 16'd2);
        tick();
        pixel(0, 8'h01);
        pixel(1, 8'h02);
        pixel(2, 8'h03);
        pix_en = 1'b0; data_valid = 1'b1; rx_byte = 8'h04;
        tick();
        data_valid = 1'b0;
        chk("abort_err", 32'(load_err), 32'd1);
        chk("abort_busy", 32'(load_busy), 32'd0);
        tick();
        chk("abort_drained", 32'(exp_q.size()), 32'd0);

        // A byte during CHECK is an error.
        start();
        header(16'd4, 16'd2);
        send(8'h99);
        chk("check_dv_err", 32'(load_err), 32'd1);
        chk("check_dv_busy", 32'(load_busy), 32'd0);
        pix_en = 1'b0;
        tick();
        tick();

        // Timeout after two header bytes.
        start();
        send(8'h00);
        send(8'h04);
        repeat (99) tick();
        chk("no_timeout_yet", 32'(load_err), 32'd0);
        chk("busy_before_to", 32'(load_busy), 32'd1);
        tick();
        chk("timeout_err", 32'(load_err), 32'd1);
        pix_en = 1'b0;
        tick();
        tick();

        // Back-to-back strobes on a 1x4 image.
        start();
        header(16'd1, 16'd4);
        tick();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            pixel(i, 8'(8'hC0 + i));
            chk("b2b_we", 32'(bram_we), 32'd1);
        end
        chk("b2b_last_addr", 32'(bram_addr), 32'd3);
        chk("b2b_done_early", 32'(load_done), 32'd0);
        tick();
        chk("b2b_done", 32'(load_done), 32'd1);
        chk("b2b_we_off", 32'(bram_we), 32'd0);
        tick();
        chk("b2b_done_pulse", 32'(load_done), 32'd0);
        chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd1);
        pix_en = 1'b0;
        tick();

        // Reset in the middle of DATA.
        start();
        header(16'd4, 16'd2);
        tick();
        pixel(0, 8'h21);
        pixel(1, 8'h22);
        reset = 1'b1; data_valid = 1'b1; rx_byte = 8'h77;
        tick();
        data_valid = 1'b0; pix_en = 1'b0;
        chk("mid_rst_we", 32'(bram_we), 32'd0);
        chk("mid_rst_en", 32'(bram_en), 32'd0);
        chk("mid_rst_addr", 32'(bram_addr), 32'd0);
        chk("mid_rst_din", 32'(bram_din), 32'd0);
        chk("mid_rst_busy", 32'(load_busy), 32'd0);
        chk("mid_rst_img", {12'd0, img_w, img_h}, 32'd0);
        reset = 1'b0;
        tick();
        send(8'h12);
        send(8'h34);
        tick();
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
